// File: rtl/eye_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eye_pkg                                                              |
// | Shared types, defaults and helpers for the eye-opening monitor.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package eye_pkg;

  typedef enum logic {EYE_AVG = 1'b0, EYE_WORST = 1'b1} eye_mode_e;
  typedef enum logic {IDLE = 1'b0, ACQUIRE = 1'b1} eye_state_e;

  localparam int  EYE_DEFAULT_WINDOW    = 300;
  localparam real EYE_DEFAULT_THRESHOLD = 0.5;

  // An empty class averages to zero rather than dividing by zero.
  function automatic real class_avg(input real sum, input logic [31:0] cnt);
    return (cnt == 32'd0) ? 0.0 : sum / real'(cnt);
  endfunction

endpackage
`default_nettype wire

// File: rtl/eye_class_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eye_class_accumulator                                                |
// | Running sum, count, min and max of the samples of one class.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module eye_class_accumulator #(
  parameter int CNT_W = 9
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear,
  input  logic             add,
  input  real              value,
  output real              sum_o,
  output logic [CNT_W-1:0] count_o,
  output real              min_o,
  output real              max_o
);

  real              sum_q, min_q, max_q;
  logic [CNT_W-1:0] count_q;

  // Outputs already include the sample being added this cycle, so the
  // owner can close a window on the same edge that accepts its last sample.
  always_comb begin
    sum_o   = sum_q;
    count_o = count_q;
    min_o   = min_q;
    max_o   = max_q;
    if (add) begin
      sum_o   = sum_q + value;
      count_o = count_q + 1'b1;
      if (count_q == '0 || value < min_q) min_o = value;
      if (count_q == '0 || value > max_q) max_o = value;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q   <= 0.0;
      count_q <= '0;
      min_q   <= 0.0;
      max_q   <= 0.0;
    end else if (clear) begin
      sum_q   <= 0.0;
      count_q <= '0;
      min_q   <= 0.0;
      max_q   <= 0.0;
    end else begin
      sum_q   <= sum_o;
      count_q <= count_o;
      min_q   <= min_o;
      max_q   <= max_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/eye_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | eye_monitor                                                          |
// | Windowed eye-opening estimator with optional threshold re-centring.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module eye_monitor
  import eye_pkg::*;
#(
  parameter int  MAX_WINDOW      = EYE_DEFAULT_WINDOW,
  parameter real INIT_THRESHOLD  = EYE_DEFAULT_THRESHOLD,
  parameter int  ADAPT_THRESHOLD = 1,
  parameter int  CNT_W           = 16
) (
  input  logic                              clock_with_shift,
  input  logic                              reset_n,
  input  logic                              enable,
  input  logic                              sample_valid,
  input  real                               sample,
  input  logic [$clog2(MAX_WINDOW+1)-1:0]   window_len,
  input  logic                              mode,
  output real                               opening,
  output real                               avg_high,
  output real                               avg_low,
  output real                               threshold,
  output logic                              opening_ready,
  output logic                              eye_closed,
  output logic [CNT_W-1:0]                  window_count
);

  localparam int LEN_W = $clog2(MAX_WINDOW + 1);

  eye_state_e       state_q, state_d;
  eye_mode_e        mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d, nsmp_q, nsmp_d;
  real              opening_q, opening_d, avg_high_q, avg_high_d;
  real              avg_low_q, avg_low_d, thr_q, thr_d;
  logic             ready_q, ready_d, closed_q, closed_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;

  logic             accept, is_high, done, acc_clear;
  real              hi_sum, hi_min, hi_max_unused, lo_sum, lo_min_unused, lo_max;
  logic [LEN_W-1:0] hi_cnt, lo_cnt;
  real              win_avg_high, win_avg_low, win_opening;
  logic             win_closed;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len == '0 || len > LEN_W'(MAX_WINDOW)) ? LEN_W'(MAX_WINDOW) : len;
  endfunction

  assign accept    = (state_q == ACQUIRE) && enable && sample_valid;
  assign is_high   = (sample >= thr_q);
  assign done      = accept && ((nsmp_q + 1'b1) == len_q);
  assign acc_clear = (state_q != ACQUIRE) || !enable || done;

  eye_class_accumulator #(.CNT_W(LEN_W)) u_high (
    .clk_i   (clock_with_shift),
    .rst_ni  (reset_n),
    .clear   (acc_clear),
    .add     (accept && is_high),
    .value   (sample),
    .sum_o   (hi_sum),
    .count_o (hi_cnt),
    .min_o   (hi_min),
    .max_o   (hi_max_unused)
  );

  eye_class_accumulator #(.CNT_W(LEN_W)) u_low (
    .clk_i   (clock_with_shift),
    .rst_ni  (reset_n),
    .clear   (acc_clear),
    .add     (accept && !is_high),
    .value   (sample),
    .sum_o   (lo_sum),
    .count_o (lo_cnt),
    .min_o   (lo_min_unused),
    .max_o   (lo_max)
  );

  always_comb begin
    win_avg_high = class_avg(hi_sum, 32'(hi_cnt));
    win_avg_low  = class_avg(lo_sum, 32'(lo_cnt));
    win_opening  = (mode_q == EYE_WORST) ? (hi_min - lo_max) : (win_avg_high - win_avg_low);
    win_closed   = (hi_cnt == '0) || (lo_cnt == '0) || (win_opening <= 0.0);
  end

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    len_d      = len_q;
    nsmp_d     = nsmp_q;
    opening_d  = opening_q;
    avg_high_d = avg_high_q;
    avg_low_d  = avg_low_q;
    thr_d      = thr_q;
    ready_d    = 1'b0;
    closed_d   = closed_q;
    wcnt_d     = wcnt_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = ACQUIRE;
          len_d   = clamp_len(window_len);
          mode_d  = eye_mode_e'(mode);
          nsmp_d  = '0;
        end
      end
      ACQUIRE: begin
        if (!enable) begin
          state_d = IDLE;
          nsmp_d  = '0;
        end else if (done) begin
          opening_d  = win_opening;
          avg_high_d = win_avg_high;
          avg_low_d  = win_avg_low;
          closed_d   = win_closed;
          ready_d    = 1'b1;
          wcnt_d     = (&wcnt_q) ? wcnt_q : wcnt_q + 1'b1;
          if (ADAPT_THRESHOLD != 0 && hi_cnt != '0 && lo_cnt != '0)
            thr_d = (win_avg_high + win_avg_low) / 2.0;
          // Back-to-back windows: the next one latches its setup here.
          len_d  = clamp_len(window_len);
          mode_d = eye_mode_e'(mode);
          nsmp_d = '0;
        end else if (accept) begin
          nsmp_d = nsmp_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_with_shift or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mode_q     <= EYE_AVG;
      len_q      <= '0;
      nsmp_q     <= '0;
      opening_q  <= 1.0;
      avg_high_q <= 0.0;
      avg_low_q  <= 0.0;
      thr_q      <= INIT_THRESHOLD;
      ready_q    <= 1'b0;
      closed_q   <= 1'b0;
      wcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      len_q      <= len_d;
      nsmp_q     <= nsmp_d;
      opening_q  <= opening_d;
      avg_high_q <= avg_high_d;
      avg_low_q  <= avg_low_d;
      thr_q      <= thr_d;
      ready_q    <= ready_d;
      closed_q   <= closed_d;
      wcnt_q     <= wcnt_d;
    end
  end

  assign opening       = opening_q;
  assign avg_high      = avg_high_q;
  assign avg_low       = avg_low_q;
  assign threshold     = thr_q;
  assign opening_ready = ready_q;
  assign eye_closed    = closed_q;
  assign window_count  = wcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_eye_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_eye_monitor                                                       |
// | Directed, scoreboard-based bench for eye_monitor.                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_eye_monitor;

  typedef struct {
    real         op;
    real         ah;
    real         al;
    real         thr;
    logic        closed;
    logic [15:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        sample_valid = 1'b0;
  logic        mode = 1'b0;
  logic [8:0]  window_len = 9'd0;
  real         sample = 0.0;

  real         opening, avg_high, avg_low, threshold;
  logic        opening_ready, eye_closed;
  logic [15:0] window_count;

  real         s_opening, s_avg_high, s_avg_low, s_threshold;
  logic        s_ready, s_closed;
  logic [1:0]  s_count;

  int          checks = 0;
  int          errors = 0;
  exp_t        sbq[$];
  exp_t        last;
  exp_t        mon_e;
  real         sq[$];
  real         mthr = 0.5;
  logic [15:0] mcnt = 16'd0;
  bit          enabled = 1'b0;

  always #5 clk = ~clk;

  eye_monitor #(.MAX_WINDOW(300), .INIT_THRESHOLD(0.5), .ADAPT_THRESHOLD(1), .CNT_W(16)) u_dut (
    .clock_with_shift (clk),
    .reset_n          (rst_n),
    .enable           (enable),
    .sample_valid     (sample_valid),
    .sample           (sample),
    .window_len       (window_len),
    .mode             (mode),
    .opening          (opening),
    .avg_high         (avg_high),
    .avg_low          (avg_low),
    .threshold        (threshold),
    .opening_ready    (opening_ready),
    .eye_closed       (eye_closed),
    .window_count     (window_count)
  );

  eye_monitor #(.MAX_WINDOW(300), .INIT_THRESHOLD(0.5), .ADAPT_THRESHOLD(0), .CNT_W(2)) u_sat (
    .clock_with_shift (clk),
    .reset_n          (rst_n),
    .enable           (enable),
    .sample_valid     (sample_valid),
    .sample           (sample),
    .window_len       (window_len),
    .mode             (mode),
    .opening          (s_opening),
    .avg_high         (s_avg_high),
    .avg_low          (s_avg_low),
    .threshold        (s_threshold),
    .opening_ready    (s_ready),
    .eye_closed       (s_closed),
    .window_count     (s_count)
  );

  function automatic bit near(input real a, input real b);
    return ((a - b) < 1e-9) && ((b - a) < 1e-9);
  endfunction

  task automatic chk_r(input string tag, input real got, input real exp);
    checks++;
    assert (near(got, exp) === 1'b1) else begin
      errors++;
      $error("FAIL %s observed %0.9f expected %0.9f", tag, got, exp);
    end
  endtask

  task automatic chk_v(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (opening_ready === 1'b1) begin
      chk_v("pulse_expected", 16'(sbq.size() != 0), 16'd1);
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        chk_r("opening", opening, mon_e.op);
        chk_r("avg_high", avg_high, mon_e.ah);
        chk_r("avg_low", avg_low, mon_e.al);
        chk_r("threshold", threshold, mon_e.thr);
        chk_v("eye_closed", 16'(eye_closed), 16'(mon_e.closed));
        chk_v("window_count", window_count, mon_e.cnt);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk_r({tag, "_opening"}, opening, 1.0);
    chk_r({tag, "_avg_high"}, avg_high, 0.0);
    chk_r({tag, "_avg_low"}, avg_low, 0.0);
    chk_r({tag, "_threshold"}, threshold, 0.5);
    chk_v({tag, "_ready"}, 16'(opening_ready), 16'd0);
    chk_v({tag, "_closed"}, 16'(eye_closed), 16'd0);
    chk_v({tag, "_count"}, window_count, 16'd0);
  endtask

  task automatic model_reset();
    mthr    = 0.5;
    mcnt    = 16'd0;
    enabled = 1'b0;
  endtask

  // Runs one window from sq, pushing the model result just before the
  // completing edge so an early pulse finds the scoreboard empty.
  task automatic run_window(input logic [8:0] wl, input bit m, input bit gaps);
    int   n, ch, cl;
    real  sh, sl, mnh, mxl, x;
    exp_t e;
    n = (wl == 9'd0 || wl > 9'd300) ? 300 : int'(wl);
    window_len = wl;
    mode       = m;
    if (!enabled) begin
      enable = 1'b1;
      tick();
      enabled = 1'b1;
    end
    sh = 0.0; sl = 0.0; mnh = 0.0; mxl = 0.0; ch = 0; cl = 0;
    for (int i = 0; i < n; i++) begin
      x = sq[i];
      if (x >= mthr) begin
        if (ch == 0 || x < mnh) mnh = x;
        sh += x;
        ch++;
      end else begin
        if (cl == 0 || x > mxl) mxl = x;
        sl += x;
        cl++;
      end
    end
    e.ah     = (ch > 0) ? sh / real'(ch) : 0.0;
    e.al     = (cl > 0) ? sl / real'(cl) : 0.0;
    e.op     = m ? (mnh - mxl) : (e.ah - e.al);
    e.closed = (ch == 0) || (cl == 0) || (e.op <= 0.0);
    if (ch > 0 && cl > 0) mthr = (e.ah + e.al) / 2.0;
    e.thr = mthr;
    if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
    e.cnt = mcnt;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) sbq.push_back(e);
      sample_valid = 1'b1;
      sample       = sq[i];
      tick();
      sample_valid = 1'b0;
      if (gaps && i != n - 1) begin
        sample = -5.0;
        tick();
      end
    end
    @(negedge clk);
    #1;
    chk_v("pulse_seen", 16'(sbq.size()), 16'd0);
    last = e;
  endtask

  task automatic stop_acq();
    enable = 1'b0;
    tick();
    enabled = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // average eye
    sq = '{1.0, 0.0, 0.9, 0.1};
    run_window(9'd4, 1'b0, 1'b0);
    chk_r("avg_opening", opening, 0.9);
    chk_r("avg_avg_high", avg_high, 0.95);
    chk_r("avg_avg_low", avg_low, 0.05);
    chk_r("avg_threshold", threshold, 0.5);
    chk_v("avg_count", window_count, 16'd1);
    stop_acq();

    // worst-case eye
    run_window(9'd4, 1'b1, 1'b0);
    chk_r("worst_opening", opening, 0.8);
    chk_v("worst_closed", 16'(eye_closed), 16'd0);
    stop_acq();

    // threshold adaptation from a fresh reset
    pulse_reset();
    sq = '{0.8, 0.6};
    run_window(9'd2, 1'b0, 1'b0);
    chk_r("adapt1_opening", opening, 0.7);
    chk_r("adapt1_avg_low", avg_low, 0.0);
    chk_v("adapt1_closed", 16'(eye_closed), 16'd1);
    chk_r("adapt1_threshold", threshold, 0.5);
    sq = '{0.8, 0.2};
    run_window(9'd2, 1'b0, 1'b0);
    chk_r("adapt2_threshold", threshold, 0.5);
    sq = '{0.8, 0.4};
    run_window(9'd2, 1'b0, 1'b0);
    chk_r("adapt3_threshold", threshold, 0.6);
    chk_r("fixed_threshold", s_threshold, 0.5);
    stop_acq();

    // invalid samples interleaved
    sq = '{0.9, 0.1, 0.8, 0.2};
    run_window(9'd4, 1'b0, 1'b1);

    // abort after two samples, then a clean window
    stop_acq();
    window_len = 9'd4;
    enable = 1'b1;
    tick();
    sample_valid = 1'b1;
    sample = 0.95;
    tick();
    sample = 0.05;
    tick();
    sample_valid = 1'b0;
    enable = 1'b0;
    tick();
    enabled = 1'b0;
    @(negedge clk);
    #1;
    chk_v("abort_no_pulse", 16'(opening_ready), 16'd0);
    chk_r("abort_opening_kept", opening, last.op);
    chk_v("abort_count_kept", window_count, mcnt);
    sq = '{1.0, 0.2, 0.7, 0.0};
    run_window(9'd4, 1'b0, 1'b0);

    // reset mid-window
    sq = '{0.9, 0.1};
    window_len = 9'd4;
    enable = 1'b1;
    tick();
    sample_valid = 1'b1;
    sample = sq[0];
    tick();
    sample = sq[1];
    tick();
    sample_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    check_reset_values("midreset");
    model_reset();
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // window_len of zero clamps to the maximum length
    sq.delete();
    for (int i = 0; i < 300; i++) sq.push_back((i % 2 == 0) ? 1.0 : 0.0);
    run_window(9'd0, 1'b0, 1'b0);
    chk_r("clamp_opening", opening, 1.0);
    stop_acq();

    // window counter saturation on the narrow instance
    pulse_reset();
    sq = '{0.8, 0.2};
    for (int w = 1; w <= 5; w++) begin
      run_window(9'd2, 1'b0, 1'b0);
      if (w == 3) chk_v("sat_after3", 16'(s_count), 16'd3);
    end
    chk_v("sat_after5", 16'(s_count), 16'd3);
    chk_v("wide_after5", window_count, 16'd5);
    stop_acq();

    repeat (3) tick();
    chk_v("scoreboard_drained", 16'(sbq.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/eye_monitor.md
# eye_monitor

Runtime-configurable successor to the fixed-window eye-opening estimator in the TX equalization behavioural model. Samples the real-valued equalizer output on the shifted sampling clock and classifies each sample as high or low against a threshold. Per window it reports an average-eye or worst-case (inner) eye opening, and can re-centre the threshold from the previous window's level averages. It sits between the equalizer model and the tap-adaptation sequence, which consumes `opening` on each `opening_ready` pulse.

## Interface
- `MAX_WINDOW`, 300: largest window length in samples; sizes `window_len`.
- `INIT_THRESHOLD`, 0.5: threshold after reset (real).
- `ADAPT_THRESHOLD`, 1: 1 enables threshold re-centring after each window; 0 keeps the threshold fixed.
- `CNT_W`, 16: width of `window_count`.
- `clock_with_shift`  in  1  sampling clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  1 = acquire windows; 0 = abort the current window and idle.
- `sample_valid`  in  1  `sample` is accepted on this edge.
- `sample`  in  real  equalizer output voltage.
- `window_len`  in  $clog2(MAX_WINDOW+1)  samples per window; latched at window start.
- `mode`  in  1  0 = average eye; 1 = worst-case eye.
- `opening`  out  real  last completed window's eye opening.
- `avg_high`, `avg_low`  out  real  last window's class averages.
- `threshold`  out  real  threshold currently used for classification.
- `opening_ready`  out  1  one-cycle pulse when a window completes.
- `eye_closed`  out  1  last window had an empty class or a non-positive opening.
- `window_count`  out  CNT_W  completed windows; saturates at all-ones.

## Operation
- FSM states are IDLE and ACQUIRE.
- IDLE -> ACQUIRE on an edge with `enable`=1. That edge latches `window_len` and `mode`.
- A latched `window_len` of 0 or greater than MAX_WINDOW is clamped to MAX_WINDOW.
- ACQUIRE -> IDLE on an edge with `enable`=0. Partial sums are discarded and outputs keep their previous values.
- In ACQUIRE, each valid sample is classified:
  - `sample >= threshold` is high.
  - Otherwise it is low.
  - The matching class sum, count, min and max are updated.
- Window completes on the edge accepting the N-th valid sample, N being the latched length.
- Results computed on completion:
  - avg_x = sum_x/count_x if count_x>0, else 0.0.
  - Mode 0: opening = avg_high − avg_low.
  - Mode 1: opening = min_high − max_low.
  - `eye_closed` = (count_high==0) | (count_low==0) | (opening<=0.0).
- Threshold update, on completion only: if ADAPT_THRESHOLD=1 and both counts are >0, threshold ← (avg_high+avg_low)/2. Otherwise the threshold is unchanged.
- After completion, accumulators clear and `window_len`/`mode` re-latch. The next window starts with the next valid sample, with no gap cycle.
- Invalid samples (`sample_valid`=0) are ignored and do not advance the count.

## Timing
- Reset values: `opening`=1.0, `avg_high`=`avg_low`=0.0, `threshold`=INIT_THRESHOLD, `opening_ready`=0, `eye_closed`=0, `window_count`=0, FSM in IDLE, accumulators cleared.
- Latency: all results and `opening_ready`=1 are visible immediately after the completing edge. The pulse lasts exactly one cycle.
- A sample accepted on the completing edge is classified against the old threshold. The new threshold applies from the next accepted sample.
- If `enable` falls on the completing edge, there is no completion: the window aborts, with no pulse and no result update.
- `window_len` or `mode` changes mid-window take effect only at the next window start.
- Asserting `reset_n` mid-window immediately clears all state to reset values; any pending pulse is lost.

## Structure
- Package `eye_pkg`:
  - `eye_mode_e` enum {EYE_AVG, EYE_WORST}.
  - `eye_state_e` enum {IDLE, ACQUIRE}.
  - Default constants `EYE_DEFAULT_WINDOW`=300 and `EYE_DEFAULT_THRESHOLD`=0.5.
- Sub-module `eye_class_accumulator`, instantiated twice (high and low class):
  - Tracks real sum, integer count, real min and real max.
  - Controls: `clear`, `add`, `value`.
- Top level holds the FSM, window counter, threshold register and result muxing.

## Test plan
Compare reals with 1e-9 tolerance.
- **Average eye:** N=4, mode 0, samples 1.0, 0.0, 0.9, 0.1 → avg_high=0.95, avg_low=0.05, opening=0.9, one pulse on the 4th edge, threshold→0.5, window_count=1.
- **Worst-case eye:** same stimulus with mode 1 → opening=0.8 (0.9−0.1), eye_closed=0.
- **Threshold adaptation:** INIT_THRESHOLD=0.5, N=2, samples 0.8 then 0.6 → low class empty, avg_low=0.0, opening=0.7, eye_closed=1, threshold stays 0.5.
  - Next window with samples 0.8, 0.2 → threshold→0.5.
  - Then a window with samples 0.8, 0.4 → threshold→0.6.
- **Invalid samples and abort:** interleave `sample_valid`=0 cycles → the pulse arrives only after N valid samples. Dropping `enable` after 2 of 4 samples → no pulse, outputs unchanged, the next window counts from zero.
- **Reset and clamp:** assert `reset_n` mid-window → all outputs return to reset values (opening=1.0). With `window_len`=0, the pulse arrives after MAX_WINDOW valid samples.
- **Saturation:** with CNT_W=2, run 5 windows → window_count reads 3 after the 3rd window and holds 3.
